// File: rtl/rs232_responder_pkg.sv
// Shared definitions for the RS232 Avalon responder.
// Holds the register byte addresses, the STATUS bit positions and the
// access FSM state type. No ports; imported by rs232_avalon_responder.
package rs232_responder_pkg;

    localparam logic [4:0] RX_BASE     = 5'd0;
    localparam logic [4:0] TX_BASE     = 5'd4;
    localparam logic [4:0] STATUS_BASE = 5'd8;

    localparam int TX_OK_BIT   = 6;
    localparam int RX_OK_BIT   = 7;
    localparam int ERR_RXU_BIT = 0;
    localparam int ERR_TXO_BIT = 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_ACK  = 2'd2
    } state_e;

endpackage

// File: rtl/sync_byte_fifo.sv
// Synchronous byte FIFO with first-word-fall-through head.
// Ports:
//   clk_i   - clock, rising edge
//   rst_ni  - asynchronous active-low reset (empties the FIFO)
//   push_i  - write data_i (ignored while full, even if popping)
//   data_i  - byte to write
//   pop_i   - drop the head entry (ignored while empty)
//   full_o  - DEPTH entries stored
//   empty_o - no entries stored
//   head_o  - oldest entry, forced to 0 while empty
module sync_byte_fifo #(
    parameter int DEPTH = 16
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       push_i,
    input  logic [7:0] data_i,
    input  logic       pop_i,
    output logic       full_o,
    output logic       empty_o,
    output logic [7:0] head_o
);

    localparam int AW = $clog2(DEPTH);

    // One extra MSB on each pointer distinguishes full from empty.
    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    logic [7:0]  mem_q [DEPTH];
    logic        do_push;
    logic        do_pop;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign head_o  = empty_o ? 8'h00 : mem_q[rd_ptr_q[AW-1:0]];

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage is data only; validity is tracked by the pointers.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
    end

endmodule

// File: rtl/rs232_avalon_responder.sv
// Avalon-MM slave modelling the RS232 UART register map.
//   0x0 RX data (read pops host byte), 0x4 TX data (write pushes byte),
//   0x8 STATUS (bit7 RX has data, bit6 TX has space).
// Each access holds waitrequest for WAIT_CYCLES extra cycles, then
// acknowledges for one cycle; the FIFO side effect lands at the end of
// that acknowledge cycle.
// Optional macro RS232_RESPONDER_ERR_FLAGS_EN adds sticky STATUS bits
// (bit0 RX underflow, bit1 TX overflow) cleared by any STATUS write.
// Ports:
//   avm_clk, avm_rst_n          - clock, asynchronous active-low reset
//   avs_address/read/write/
//   avs_writedata/readdata/
//   avs_waitrequest             - Avalon-MM slave
//   i_rx_valid/i_rx_data/
//   o_rx_ready                  - host byte stream into the RX FIFO
//   o_tx_valid/o_tx_data/
//   i_tx_ready                  - byte stream out of the TX FIFO
module rs232_avalon_responder
    import rs232_responder_pkg::*;
#(
    parameter int FIFO_DEPTH  = 16,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        avm_clk,
    input  logic        avm_rst_n,
    input  logic [4:0]  avs_address,
    input  logic        avs_read,
    input  logic        avs_write,
    input  logic [31:0] avs_writedata,
    output logic [31:0] avs_readdata,
    output logic        avs_waitrequest,
    input  logic        i_rx_valid,
    input  logic [7:0]  i_rx_data,
    output logic        o_rx_ready,
    output logic        o_tx_valid,
    output logic [7:0]  o_tx_data,
    input  logic        i_tx_ready
);

    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    state_e      state_q, state_d;
    logic [4:0]  addr_q, addr_d;
    logic        wr_q, wr_d;
    logic [7:0]  wdata_q, wdata_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] rdata_q, rdata_d;
    logic        pop_ok_q, pop_ok_d;

    logic        req;
    logic        enter_ack;
    logic        ack;
    logic [4:0]  cur_addr;
    logic        cur_wr;
    logic [31:0] status_w;
    logic [31:0] snap_data;
    logic        snap_pop;

    logic        rx_full, rx_empty, rx_pop;
    logic [7:0]  rx_head;
    logic        tx_full, tx_empty, tx_push, tx_pop;
    logic [7:0]  tx_head;

    wire unused_wdata_hi = ^avs_writedata[31:8];

    assign req             = avs_read || avs_write;
    assign ack             = (state_q == S_ACK);
    assign avs_waitrequest = !ack;
    assign avs_readdata    = rdata_q;

    // In S_IDLE the request is still on the bus; afterwards use the latch.
    // Write wins when read and write are both asserted.
    assign cur_addr = (state_q == S_IDLE) ? avs_address : addr_q;
    assign cur_wr   = (state_q == S_IDLE) ? avs_write   : wr_q;

`ifdef RS232_RESPONDER_ERR_FLAGS_EN
    logic rxu_q, rxu_d;
    logic txo_q, txo_d;
    logic rxu_set, txo_set, err_clr;

    assign rxu_set = ack && !wr_q && (addr_q == RX_BASE) && !pop_ok_q;
    assign txo_set = ack &&  wr_q && (addr_q == TX_BASE) && tx_full;
    assign err_clr = ack &&  wr_q && (addr_q == STATUS_BASE);

    // Set dominates clear when both land on the same edge.
    assign rxu_d = (rxu_q && !err_clr) || rxu_set;
    assign txo_d = (txo_q && !err_clr) || txo_set;

    always_ff @(posedge avm_clk or negedge avm_rst_n) begin
        if (!avm_rst_n) begin
            rxu_q <= 1'b0;
            txo_q <= 1'b0;
        end else begin
            rxu_q <= rxu_d;
            txo_q <= txo_d;
        end
    end
`endif

    always_comb begin
        status_w            = '0;
        status_w[RX_OK_BIT] = !rx_empty;
        status_w[TX_OK_BIT] = !tx_full;
`ifdef RS232_RESPONDER_ERR_FLAGS_EN
        status_w[ERR_RXU_BIT] = rxu_q;
        status_w[ERR_TXO_BIT] = txo_q;
`endif
    end

    // Read data and the RX pop decision are captured together so the pop
    // matches exactly the byte that was returned.
    always_comb begin
        snap_data = '0;
        snap_pop  = 1'b0;
        if (!cur_wr) begin
            case (cur_addr)
                RX_BASE: begin
                    if (!rx_empty) begin
                        snap_data = {24'h0, rx_head};
                        snap_pop  = 1'b1;
                    end
                end
                STATUS_BASE: snap_data = status_w;
                default: ;
            endcase
        end
    end

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wr_d      = wr_q;
        wdata_d   = wdata_q;
        cnt_d     = cnt_q;
        rdata_d   = rdata_q;
        pop_ok_d  = pop_ok_q;
        enter_ack = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    addr_d  = avs_address;
                    wr_d    = avs_write;
                    wdata_d = avs_writedata[7:0];
                    cnt_d   = WAIT_INIT;
                    if (WAIT_CYCLES == 0) enter_ack = 1'b1;
                    else                  state_d   = S_WAIT;
                end
            end
            S_WAIT: begin
                if (!req)                  state_d   = S_IDLE;
                else if (cnt_q <= 4'd1)    enter_ack = 1'b1;
                else                       cnt_d     = cnt_q - 4'd1;
            end
            S_ACK:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (enter_ack) begin
            state_d  = S_ACK;
            rdata_d  = snap_data;
            pop_ok_d = snap_pop;
        end
    end

    always_ff @(posedge avm_clk or negedge avm_rst_n) begin
        if (!avm_rst_n) begin
            state_q  <= S_IDLE;
            wr_q     <= 1'b0;
            cnt_q    <= '0;
            rdata_q  <= '0;
            pop_ok_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_q     <= wr_d;
            cnt_q    <= cnt_d;
            rdata_q  <= rdata_d;
            pop_ok_q <= pop_ok_d;
        end
    end

    always_ff @(posedge avm_clk) begin
        addr_q  <= addr_d;
        wdata_q <= wdata_d;
    end

    assign rx_pop     = ack && pop_ok_q;
    assign tx_push    = ack && wr_q && (addr_q == TX_BASE) && !tx_full;
    assign o_rx_ready = !rx_full;
    assign o_tx_valid = !tx_empty;
    assign o_tx_data  = tx_head;
    assign tx_pop     = o_tx_valid && i_tx_ready;

    sync_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk_i   (avm_clk),
        .rst_ni  (avm_rst_n),
        .push_i  (i_rx_valid && o_rx_ready),
        .data_i  (i_rx_data),
        .pop_i   (rx_pop),
        .full_o  (rx_full),
        .empty_o (rx_empty),
        .head_o  (rx_head)
    );

    sync_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk_i   (avm_clk),
        .rst_ni  (avm_rst_n),
        .push_i  (tx_push),
        .data_i  (wdata_q),
        .pop_i   (tx_pop),
        .full_o  (tx_full),
        .empty_o (tx_empty),
        .head_o  (tx_head)
    );

endmodule

// File: tb/tb_rs232_avalon_responder.sv
module tb_rs232_avalon_responder;

    localparam int DEPTH = 16;
    localparam int WAITC = 1;
`ifdef RS232_RESPONDER_ERR_FLAGS_EN
    localparam logic [31:0] RXU_FLAG = 32'h1;
    localparam logic [31:0] TXO_FLAG = 32'h2;
`else
    localparam logic [31:0] RXU_FLAG = 32'h0;
    localparam logic [31:0] TXO_FLAG = 32'h0;
`endif

    logic        avm_clk = 1'b0;
    logic        avm_rst_n = 1'b0;
    logic [4:0]  avs_address = '0;
    logic        avs_read = 1'b0;
    logic        avs_write = 1'b0;
    logic [31:0] avs_writedata = '0;
    logic [31:0] avs_readdata;
    logic        avs_waitrequest;
    logic        i_rx_valid = 1'b0;
    logic [7:0]  i_rx_data = '0;
    logic        o_rx_ready;
    logic        o_tx_valid;
    logic [7:0]  o_tx_data;
    logic        i_tx_ready = 1'b0;

    int total = 0;
    int bad   = 0;
    logic [31:0] exp_q[$];
    logic [7:0]  tx_exp_q[$];
    int          tx_model_cnt = 0;

    rs232_avalon_responder #(.FIFO_DEPTH(DEPTH), .WAIT_CYCLES(WAITC)) dut (
        .avm_clk         (avm_clk),
        .avm_rst_n       (avm_rst_n),
        .avs_address     (avs_address),
        .avs_read        (avs_read),
        .avs_write       (avs_write),
        .avs_writedata   (avs_writedata),
        .avs_readdata    (avs_readdata),
        .avs_waitrequest (avs_waitrequest),
        .i_rx_valid      (i_rx_valid),
        .i_rx_data       (i_rx_data),
        .o_rx_ready      (o_rx_ready),
        .o_tx_valid      (o_tx_valid),
        .o_tx_data       (o_tx_data),
        .i_tx_ready      (i_tx_ready)
    );

    always #5 avm_clk = ~avm_clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // One Avalon access; entered and left at posedge+1.
    // Reads compare against the scoreboard head.
    task automatic bus(input bit wr, input logic [4:0] addr, input logic [7:0] wd,
                       input string tag, output logic rdy_ack);
        int n;
        bit done;
        logic [31:0] exp;
        avs_address   = addr;
        avs_write     = wr;
        avs_read      = !wr;
        avs_writedata = {24'hABCDEF, wd};
        n = 0;
        done = 0;
        while (!done && n < 20) begin
            @(negedge avm_clk);
            n++;
            if (!avs_waitrequest) done = 1;
        end
        rdy_ack = o_rx_ready;
        check({tag, " latency"}, 32'(n), 32'(WAITC + 2));
        if (!wr) begin
            exp = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEADBEEF;
            check({tag, " readdata"}, avs_readdata, exp);
        end
        @(posedge avm_clk);
        #1;
        avs_read  = 1'b0;
        avs_write = 1'b0;
    endtask

    task automatic rd(input logic [4:0] addr, input logic [31:0] exp, input string tag);
        logic r;
        exp_q.push_back(exp);
        bus(1'b0, addr, 8'h00, tag, r);
    endtask

    task automatic wr_tx(input logic [7:0] b);
        logic r;
        if (tx_model_cnt < DEPTH) begin
            tx_exp_q.push_back(b);
            tx_model_cnt++;
        end
        bus(1'b1, 5'd4, b, "wr_tx", r);
    endtask

    task automatic rx_push(input logic [7:0] b);
        i_rx_valid = 1'b1;
        i_rx_data  = b;
        @(posedge avm_clk);
        #1;
        i_rx_valid = 1'b0;
    endtask

    initial begin
        logic r;
        int got;

        // reset values
        repeat (3) @(negedge avm_clk);
        check("rst waitrequest", 32'(avs_waitrequest), 32'h1);
        check("rst readdata", avs_readdata, 32'h0);
        check("rst tx_valid", 32'(o_tx_valid), 32'h0);
        check("rst tx_data", 32'(o_tx_data), 32'h0);
        check("rst rx_ready", 32'(o_rx_ready), 32'h1);
        avm_rst_n = 1'b1;
        @(posedge avm_clk);
        #1;

        rd(5'd8, 32'h40, "status idle");

        // RX path
        rx_push(8'hA5);
        rx_push(8'h3C);
        rd(5'd8, 32'hC0, "status rx data");
        rd(5'd0, 32'hA5, "rx first");
        rd(5'd0, 32'h3C, "rx second");
        rd(5'd8, 32'h40, "status rx drained");

        // TX fill to full, one extra dropped
        for (int i = 0; i < 16; i++) wr_tx(8'(i));
        rd(5'd8, 32'h00, "status tx full");
        check("tx_valid full", 32'(o_tx_valid), 32'h1);
        wr_tx(8'h10);
        i_tx_ready = 1'b1;
        got = 0;
        for (int k = 0; k < 40 && tx_exp_q.size() > 0; k++) begin
            @(negedge avm_clk);
            if (o_tx_valid) begin
                check("tx stream byte", 32'(o_tx_data), 32'(tx_exp_q.pop_front()));
                got++;
            end
        end
        check("tx stream count", 32'(got), 32'd16);
        @(negedge avm_clk);
        check("tx drained", 32'(o_tx_valid), 32'h0);
        @(posedge avm_clk);
        #1;
        i_tx_ready = 1'b0;
        tx_model_cnt = 0;
        rd(5'd8, 32'h40 | TXO_FLAG, "status after overflow");
        bus(1'b1, 5'd8, 8'hFF, "wr status", r);
        rd(5'd8, 32'h40, "status cleared");

        // empty RX read, optional underflow flag
        rd(5'd0, 32'h0, "rx empty");
        rd(5'd8, 32'h40 | RXU_FLAG, "status after underflow");
        bus(1'b1, 5'd8, 8'h00, "wr status", r);
        rd(5'd8, 32'h40, "status cleared 2");

        // no-effect registers
        rd(5'd12, 32'h0, "unmapped read");
        rd(5'd4, 32'h0, "tx read");
        bus(1'b1, 5'd0, 8'h77, "wr rx", r);
        rd(5'd8, 32'h40, "status after wr rx");

        // reset during S_WAIT of an RX read
        rx_push(8'h01);
        rx_push(8'h02);
        rx_push(8'h03);
        rd(5'd8, 32'hC0, "status 3 queued");
        avs_address = 5'd0;
        avs_read    = 1'b1;
        @(negedge avm_clk);
        check("abort cycle1 waitreq", 32'(avs_waitrequest), 32'h1);
        @(posedge avm_clk);
        #1;
        avm_rst_n = 1'b0;
        #1;
        avs_read = 1'b0;
        check("midrst waitrequest", 32'(avs_waitrequest), 32'h1);
        check("midrst readdata", avs_readdata, 32'h0);
        check("midrst tx_valid", 32'(o_tx_valid), 32'h0);
        check("midrst tx_data", 32'(o_tx_data), 32'h0);
        check("midrst rx_ready", 32'(o_rx_ready), 32'h1);
        @(negedge avm_clk);
        avm_rst_n = 1'b1;
        @(posedge avm_clk);
        #1;
        rd(5'd8, 32'h40, "status after midrst");

        // RX full while host read pops
        for (int i = 0; i < 16; i++) begin
            rx_push(8'(8'h20 + i));
            if (i > 0) exp_q.push_back(32'(8'h20 + i));
        end
        @(negedge avm_clk);
        check("rx full ready", 32'(o_rx_ready), 32'h0);
        @(posedge avm_clk);
        #1;
        i_rx_valid = 1'b1;
        i_rx_data  = 8'hEE;
        exp_q.push_front(32'h20);
        bus(1'b0, 5'd0, 8'h00, "rx full read", r);
        check("rx ready in pop cycle", 32'(r), 32'h0);
        @(negedge avm_clk);
        check("rx ready after pop", 32'(o_rx_ready), 32'h1);
        @(posedge avm_clk);
        #1;
        i_rx_valid = 1'b0;
        @(negedge avm_clk);
        check("rx ready refilled", 32'(o_rx_ready), 32'h0);
        @(posedge avm_clk);
        #1;
        exp_q.push_back(32'hEE);
        for (int i = 0; i < 16; i++) bus(1'b0, 5'd0, 8'h00, "rx drain", r);
        rd(5'd8, 32'h40, "status rx drained final");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
